// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Imported by seq_detector_param and its history shift register.
package seq_det_pkg;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    // Ceiling log2, never less than 1 so it can size a vector.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_hist_sr.sv
// History shift register holding the most recent accepted bits.
// Shifts in one bit per enable; sync reset and sync clear.
module seq_hist_sr
    import seq_det_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_next;

    if (W == 1) begin : g_one
        assign w_next = i_bit;
    end else begin : g_many
        assign w_next = {r_q[W-2:0], i_bit};
    end

    // Shift the newest bit in at the LSB end.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable N-bit serial pattern detector with match counter.
// Overlapping or non-overlapping detection, Mealy or registered match.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PAT_RST = 4'b1101,
    parameter int             CNT_W   = 8,
    parameter int             REG_OUT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_bit,
    input  logic                    overlap,
    input  logic                    pat_load,
    input  logic [N-1:0]            pat_value,
    input  logic                    cnt_clr,
    output logic                    match,
    output logic [CNT_W-1:0]        match_cnt,
    output logic [clog2(N+1)-1:0]   fill
);

    localparam int FILL_W = clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_MAX =
        FILL_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]      r_pattern;
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0]  r_cnt;
    logic [N-2:0]      w_hist;
    logic [N-1:0]      w_cand;
    logic              w_accept;
    logic              w_hit;

    // A concurrent pattern load discards the incoming bit.
    assign w_accept = in_valid && !pat_load;
    assign w_cand   = {w_hist, in_bit};
    assign w_hit    = w_accept
                   && (r_fill == FILL_MAX)
                   && (w_cand == r_pattern);

    seq_hist_sr #(
        .W     (N - 1)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .i_clr (pat_load),
        .i_en  (w_accept),
        .i_bit (in_bit),
        .o_q   (w_hist)
    );

    // Pattern register: reset value or runtime load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= PAT_RST;
        end else if (pat_load) begin
            r_pattern <= pat_value;
        end
    end

    // Fill tracks fresh bits; a non-overlap hit opens a new window.
    always_ff @(posedge clk) begin
        if (rst || pat_load) begin
            r_fill <= '0;
        end else if (w_accept) begin
            if (w_hit && overlap == MODE_NONOVERLAP) begin
                r_fill <= '0;
            end else if (r_fill < FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Saturating match counter; clear wins over a coincident hit.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_hit && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic r_match;

        // Registered match, one cycle after the final bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_match <= 1'b0;
            end else begin
                r_match <= w_hit;
            end
        end

        assign match = r_match;
    end else begin : g_comb
        assign match = w_hit && !rst;
    end

    assign match_cnt = r_cnt;
    assign fill      = r_fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations driven in
// parallel, checked against a bit-queue reference model.
module tb_seq_detector_param;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_value;
    logic       cnt_clr;

    logic       m0, m1, m2;
    logic [7:0] c0, c2;
    logic [1:0] c1;
    logic [2:0] f0, f1, f2;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] m_pat;
    int         m_q[$];
    int         m_since;
    int         m_c8;
    int         m_c2;
    bit         m_regm;

    seq_detector_param dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_bit(in_bit), .overlap(overlap),
        .pat_load(pat_load), .pat_value(pat_value),
        .cnt_clr(cnt_clr), .match(m0),
        .match_cnt(c0), .fill(f0)
    );

    seq_detector_param #(.CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_bit(in_bit), .overlap(overlap),
        .pat_load(pat_load), .pat_value(pat_value),
        .cnt_clr(cnt_clr), .match(m1),
        .match_cnt(c1), .fill(f1)
    );

    seq_detector_param #(.REG_OUT(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_bit(in_bit), .overlap(overlap),
        .pat_load(pat_load), .pat_value(pat_value),
        .cnt_clr(cnt_clr), .match(m2),
        .match_cnt(c2), .fill(f2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Last N accepted bits (including b) equal the pattern, and
    // at least N-1 fresh bits precede b in the current window.
    function automatic bit model_hit(bit v, bit b, bit ld);
        int w;
        if (!v || ld || m_since < N - 1) return 1'b0;
        w = 0;
        foreach (m_q[i]) w = (w << 1) | m_q[i];
        w = (w << 1) | int'(b);
        return (w[3:0] == m_pat);
    endfunction

    function automatic int min3(int x);
        return (x > N - 1) ? N - 1 : x;
    endfunction

    task automatic step(input bit v, input bit b,
                        input bit ov, input bit ld,
                        input logic [3:0] pv,
                        input bit clr, input bit r);
        bit hit;
        @(negedge clk);
        in_valid  = v;
        in_bit    = b;
        overlap   = ov;
        pat_load  = ld;
        pat_value = pv;
        cnt_clr   = clr;
        rst       = r;
        #1;
        hit = model_hit(v, b, ld);
        chk("match_mealy", 32'(m0), 32'(hit && !r));
        chk("match_mealy_c2", 32'(m1), 32'(hit && !r));
        @(posedge clk);
        #1;
        if (r) begin
            m_pat   = 4'b1101;
            m_q.delete();
            m_since = 0;
            m_c8    = 0;
            m_c2    = 0;
            m_regm  = 1'b0;
        end else begin
            m_regm = hit;
            if (clr) begin
                m_c8 = 0;
                m_c2 = 0;
            end else if (hit) begin
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3) m_c2++;
            end
            if (ld) begin
                m_pat   = pv;
                m_q.delete();
                m_since = 0;
            end else if (v) begin
                m_q.push_back(int'(b));
                if (m_q.size() > N - 1) void'(m_q.pop_front());
                if (hit && !ov) m_since = 0;
                else m_since++;
            end
        end
        chk("match_reg", 32'(m2), 32'(m_regm));
        chk("cnt8", 32'(c0), 32'(m_c8));
        chk("cnt2", 32'(c1), 32'(m_c2));
        chk("cnt8_reg", 32'(c2), 32'(m_c8));
        chk("fill", 32'(f0), 32'(min3(m_since)));
        chk("fill_c2", 32'(f1), 32'(min3(m_since)));
        chk("fill_reg", 32'(f2), 32'(min3(m_since)));
    endtask

    task automatic bits(input logic [15:0] s, input int n,
                        input bit ov);
        for (int i = n - 1; i >= 0; i--) begin
            step(1, s[i], ov, 0, 4'h0, 0, 0);
        end
    endtask

    task automatic do_rst();
        step(0, 0, 0, 0, 4'h0, 0, 1);
    endtask

    initial begin
        bit ov_r;
        rst = 1'b1; in_valid = 0; in_bit = 0; overlap = 0;
        pat_load = 0; pat_value = '0; cnt_clr = 0;
        m_pat = 4'b1101; m_since = 0; m_c8 = 0; m_c2 = 0;
        m_regm = 0;

        // 1: non-overlap, 1101101 -> one match
        do_rst();
        bits(16'b1101101, 7, 0);
        chk("t1_cnt", 32'(c0), 32'd1);

        // 2: overlap, same stream -> two matches
        do_rst();
        bits(16'b1101101, 7, 1);
        chk("t2_cnt", 32'(c0), 32'd2);

        // 3: gaps do not break progress
        do_rst();
        bits(16'b11, 2, 0);
        repeat (3) step(0, 1, 0, 0, 4'h0, 0, 0);
        bits(16'b0, 1, 0);
        step(1, 1, 0, 0, 4'h0, 0, 0);
        chk("t3_cnt", 32'(c0), 32'd1);

        // 4: load 0110 with a concurrent bit, then match it
        do_rst();
        step(1, 1, 0, 1, 4'b0110, 0, 0);
        bits(16'b0110, 4, 0);
        chk("t4_cnt", 32'(c0), 32'd1);
        bits(16'b1101, 4, 0);
        chk("t4_old", 32'(c0), 32'd1);

        // 5: saturation of 2-bit counter, clear beats hit
        do_rst();
        bits(16'b1101101101101, 13, 1);
        chk("t5_sat", 32'(c1), 32'd3);
        bits(16'b10, 2, 1);
        step(1, 1, 1, 0, 4'h0, 1, 0);
        chk("t5_clr", 32'(c1), 32'd0);

        // 6: registered match one cycle late; reset mid-pattern
        do_rst();
        bits(16'b1101, 4, 0);
        chk("t6_reg", 32'(m2), 32'd1);
        do_rst();
        bits(16'b110, 3, 0);
        do_rst();
        chk("t6_rst_m", 32'(m2), 32'd0);
        chk("t6_rst_f", 32'(f2), 32'd0);
        chk("t6_rst_c", 32'(c2), 32'd0);
        bits(16'b1, 1, 0);
        chk("t6_nomatch", 32'(m2), 32'd0);

        // Random traffic against the model
        ov_r = 0;
        repeat (600) begin
            if ($urandom_range(0, 9) == 0) ov_r = ~ov_r;
            step($urandom_range(0, 3) != 0,
                 1'($urandom),
                 ov_r,
                 $urandom_range(0, 39) == 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
